sram_like_bridge_wb: RTL

Parametrised SRAM-to-SRAM-like bridge that replaces the separate instruction and data bridges between the `mips` core and the SRAM-like bus. It converts the core's single-cycle SRAM-style port into `req`/`addr_ok`/`data_ok` transactions and holds completed results across global pipeline stalls. It adds a posted write buffer of configurable depth, so stores retire without waiting for `data_ok`. It also derives `size` and address from byte enables.

---
 rtl/sram_like_bridge_wb.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sram_like_bridge_wb.sv
// ---------------------------------------------------------------------------
// sram_like_bridge_wb
//
// Bridges the core's single-cycle SRAM-style port onto an SRAM-like bus
// (req / addr_ok / data_ok). Completed accesses are held across global
// pipeline stalls. Stores go through a posted write buffer of WBUF_DEPTH
// entries; WBUF_DEPTH = 0 gives blocking writes (instruction-port use).
// Bus size and low address bits are derived from the byte enables.
//
// Parameters
//   ADDR_W      address width
//   WBUF_DEPTH  posted write buffer entries (0 = blocking writes)
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   sram_en            core access request, held while stall is high
//   sram_wen[3:0]      byte enables, 0 = read
//   sram_addr          core byte address
//   sram_wdata         store data, byte-lane aligned
//   sram_rdata         load data, valid in the cycle stall falls for a read
//   stall              access not yet accepted
//   longest_stall      global pipeline stall (pipeline advances when 0)
//   wbuf_empty         no buffered write and no write on the bus
//   req, wr, size,
//   addr, wdata        SRAM-like request fields
//   addr_ok, data_ok,
//   rdata              SRAM-like responses
// ---------------------------------------------------------------------------
module sram_like_bridge_wb #(
  parameter int ADDR_W     = 32,
  parameter int WBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sram_en,
  input  logic [3:0]        sram_wen,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_wdata,
  output logic [31:0]       sram_rdata,
  output logic              stall,
  input  logic              longest_stall,
  output logic              wbuf_empty,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [31:0]       rdata
);

  localparam int CNT_W = (WBUF_DEPTH > 0) ? $clog2(WBUF_DEPTH + 1) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WBUF_DEPTH);
  localparam bit BLOCKING = (WBUF_DEPTH == 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_W_ADDR = 3'd1;
  localparam logic [2:0] S_W_DATA = 3'd2;
  localparam logic [2:0] S_R_ADDR = 3'd3;
  localparam logic [2:0] S_R_DATA = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic              done;
  logic [31:0]       rdata_q;

  logic [1:0]        enc_size;
  logic [1:0]        enc_lo;
  logic [ADDR_W-1:0] enc_addr;

  logic              pending_write, pending_read;
  logic              enq, pop;
  logic              rd_done, wr_done, accept_now;

  logic [ADDR_W-1:0] head_addr;
  logic [1:0]        head_size;
  logic [31:0]       head_wdata;

  // Byte enables -> bus size and low address bits. A read (wen = 0) falls
  // into the default arm, which is exactly the word-aligned read encoding.
  // NOTE: every output of a combinational block gets a default first so no
  // path through the block can infer a latch.
  always_comb begin
    enc_size = 2'd2;
    enc_lo   = 2'b00;
    case (sram_wen)
      4'b0001: begin enc_size = 2'd0; enc_lo = 2'b00; end
      4'b0010: begin enc_size = 2'd0; enc_lo = 2'b01; end
      4'b0100: begin enc_size = 2'd0; enc_lo = 2'b10; end
      4'b1000: begin enc_size = 2'd0; enc_lo = 2'b11; end
      4'b0011: begin enc_size = 2'd1; enc_lo = 2'b00; end
      4'b1100: begin enc_size = 2'd1; enc_lo = 2'b10; end
      default: begin enc_size = 2'd2; enc_lo = 2'b00; end
    endcase
  end

  assign enc_addr = {sram_addr[ADDR_W-1:2], enc_lo};

  // A repeated sram_en after completion (done) is the same access held by a
  // stalled pipeline and must not be reissued.
  assign pending_write = sram_en & (|sram_wen) & ~done;
  assign pending_read  = sram_en & ~(|sram_wen) & ~done;

  assign rd_done = (state == S_R_DATA) & data_ok;
  assign wr_done = (state == S_W_DATA) & data_ok;

  generate
    if (WBUF_DEPTH > 0) begin : g_wbuf
      localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
      localparam logic [PTR_W-1:0] LAST = PTR_W'(WBUF_DEPTH - 1);

      logic [ADDR_W-1:0] mem_addr  [WBUF_DEPTH];
      logic [1:0]        mem_size  [WBUF_DEPTH];
      logic [31:0]       mem_wdata [WBUF_DEPTH];
      logic [PTR_W-1:0]  wr_ptr, rd_ptr;

      assign pop = wr_done;
      // A full buffer still takes the store in the cycle the head retires.
      assign enq = pending_write & ((count < DEPTH_C) | pop);

      // NOTE: the entry storage has no reset; count alone says which
      // entries are live, so clearing the data would buy nothing.
      always_ff @(posedge clk) begin
        if (enq) begin
          mem_addr[wr_ptr]  <= enc_addr;
          mem_size[wr_ptr]  <= enc_size;
          mem_wdata[wr_ptr] <= sram_wdata;
        end
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (enq) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
          if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
        end
      end

      assign head_addr  = mem_addr[rd_ptr];
      assign head_size  = mem_size[rd_ptr];
      assign head_wdata = mem_wdata[rd_ptr];
    end else begin : g_nobuf
      // Blocking mode: the held core operands are the write to issue.
      assign pop        = 1'b0;
      assign enq        = 1'b0;
      assign head_addr  = enc_addr;
      assign head_size  = enc_size;
      assign head_wdata = sram_wdata;
    end
  endgenerate

  assign accept_now = enq | rd_done | (BLOCKING & wr_done);

  // Issue FSM. Writes take priority, and a read only starts from IDLE with
  // the buffer empty, so reads never overtake buffered stores.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if ((count != '0) | enq)          state_nxt = S_W_ADDR;
        else if (pending_read)            state_nxt = S_R_ADDR;
        else if (BLOCKING & pending_write) state_nxt = S_W_ADDR;
      end
      S_W_ADDR: if (addr_ok) state_nxt = S_W_DATA;
      S_W_DATA: if (data_ok) state_nxt = S_IDLE;
      S_R_ADDR: if (addr_ok) state_nxt = S_R_DATA;
      S_R_DATA: if (data_ok) state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      count   <= '0;
      done    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (enq & ~pop)      count <= count + CNT_W'(1);
      else if (pop & ~enq) count <= count - CNT_W'(1);
      if (rd_done) rdata_q <= rdata;
      // done remembers an access that completed while the pipeline was
      // frozen; it lives only until the pipeline moves again.
      if (!longest_stall)  done <= 1'b0;
      else if (accept_now) done <= 1'b1;
    end
  end

  // Request fields come straight from state so they are stable from req
  // assertion until addr_ok and drop in the cycle after it.
  always_comb begin
    req   = 1'b0;
    wr    = 1'b0;
    size  = 2'd0;
    addr  = '0;
    wdata = '0;
    case (state)
      S_W_ADDR: begin
        req   = 1'b1;
        wr    = 1'b1;
        size  = head_size;
        addr  = head_addr;
        wdata = head_wdata;
      end
      S_R_ADDR: begin
        req  = 1'b1;
        size = 2'd2;
        addr = enc_addr;
      end
      default: ;
    endcase
  end

  // Gating with resetn keeps stall low while the bridge is held in reset,
  // even if the core still presents an access.
  assign stall      = resetn & sram_en & ~done & ~accept_now;
  assign sram_rdata = rd_done ? rdata : rdata_q;
  assign wbuf_empty = (count == '0) & (state != S_W_ADDR) & (state != S_W_DATA);

endmodule
